// File: rtl/factorial_seq_ctrl_pkg.sv
// Shared types and widths for the factorial sequencer and its booth multiplier.
// The booth wrapper reuses op_w/prod_w so the operand widths stay in one place.
package factorial_seq_ctrl_pkg;

    localparam int WIDTH_DEF       = 16;
    localparam int NW_DEF          = 5;
    localparam int MUL_LATENCY_DEF = 18;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACCUM,
        DONE
    } state_t;

    function automatic int op_w(input int w);
        return w + 1;
    endfunction

    function automatic int prod_w(input int w);
        return 2 * (w + 1);
    endfunction

endpackage

// File: rtl/factorial_seq_ctrl_if.sv
// Request/result and booth-operand bundle of the factorial sequencer.
// master is the sequencer side; slave is the requester plus booth unit.
interface factorial_seq_ctrl_if
    import factorial_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NW    = NW_DEF
);
    localparam int OW = op_w(WIDTH);
    localparam int PW = prod_w(WIDTH);

    logic             start;
    logic [NW-1:0]    n;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic [OW-1:0]    mul_a;
    logic [OW-1:0]    mul_b;
    logic [PW-1:0]    mul_p;

    modport master (
        input  start, n, mul_p,
        output busy, done, result, overflow, mul_a, mul_b
    );

    modport slave (
        output start, n, mul_p,
        input  busy, done, result, overflow, mul_a, mul_b
    );

endinterface

// File: rtl/factorial_lat_cnt.sv
// Loadable down-counter; last is high on the final cycle of a count.
// Holds at zero once expired so a stray enable cannot wrap it.
module factorial_lat_cnt #(
    parameter int MAX = 18
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic last
);
    localparam int CW = $clog2(MAX + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(MAX);
        end else if (en && cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign last = (cnt == CW'(1));

endmodule

// File: rtl/factorial_seq_ctrl.sv
// Sequences acc*i products through an external booth multiplier to form n!.
// Stops early and flags overflow once a product no longer fits WIDTH bits.
module factorial_seq_ctrl
    import factorial_seq_ctrl_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int NW          = NW_DEF,
    parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
    input logic                  clk,
    input logic                  rst,
    factorial_seq_ctrl_if.master bus
);
    localparam int OW = op_w(WIDTH);
    localparam int PW = prod_w(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [NW-1:0]    n_q;
    logic [NW-1:0]    i;
    logic [WIDTH-1:0] acc;
    logic [PW-1:0]    prod;
    logic             prod_ovf;
    logic             cnt_last;

    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic [OW-1:0]    mul_a;
    logic [OW-1:0]    mul_b;

    assign prod_ovf = |prod[PW-1:WIDTH];

    factorial_lat_cnt #(
        .MAX (MUL_LATENCY)
    ) u_lat_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (state == ISSUE),
        .en   (state == WAIT),
        .last (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.n < NW'(2)) ? DONE : ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (cnt_last) begin
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (prod_ovf || i == n_q) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = ISSUE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            result   <= WIDTH'(1);
            mul_a    <= '0;
            mul_b    <= '0;
            acc      <= WIDTH'(1);
            i        <= '0;
            n_q      <= '0;
            prod     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        n_q      <= bus.n;
                        acc      <= WIDTH'(1);
                        i        <= NW'(2);
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ISSUE: begin
                    mul_a <= {1'b0, acc};
                    mul_b <= OW'(i);
                end
                WAIT: begin
                    if (cnt_last) begin
                        prod <= bus.mul_p;
                    end
                end
                ACCUM: begin
                    // i only advances when another issue follows
                    if (prod_ovf) begin
                        overflow <= 1'b1;
                    end else begin
                        acc <= prod[WIDTH-1:0];
                        if (i != n_q) begin
                            i <= i + NW'(1);
                        end
                    end
                end
                DONE: begin
                    done   <= 1'b1;
                    result <= acc;
                    busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.result   = result;
    assign bus.overflow = overflow;
    assign bus.mul_a    = mul_a;
    assign bus.mul_b    = mul_b;

endmodule

// File: tb/tb_factorial_seq_ctrl.sv
// Directed bench: three sequencers (latency 4, 1, 18) with pipelined multiplier models.
// Expected results, latencies and operand sequences are hand-computed constants.
module tb_factorial_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nchk = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    factorial_seq_ctrl_if #(.WIDTH(16), .NW(5)) b4 ();
    factorial_seq_ctrl_if #(.WIDTH(16), .NW(5)) b1 ();
    factorial_seq_ctrl_if #(.WIDTH(16), .NW(5)) b18 ();

    factorial_seq_ctrl #(.WIDTH(16), .NW(5), .MUL_LATENCY(4))
        u4 (.clk(clk), .rst(rst), .bus(b4));
    factorial_seq_ctrl #(.WIDTH(16), .NW(5), .MUL_LATENCY(1))
        u1 (.clk(clk), .rst(rst), .bus(b1));
    factorial_seq_ctrl #(.WIDTH(16), .NW(5), .MUL_LATENCY(18))
        u18 (.clk(clk), .rst(rst), .bus(b18));

    // Booth models: product valid exactly L edges after operands change
    logic [33:0] p4 [3];
    logic [33:0] p18 [17];

    always @(posedge clk) begin
        p4[0] <= 34'(b4.mul_a) * 34'(b4.mul_b);
        for (int k = 1; k < 3; k++) p4[k] <= p4[k-1];
        p18[0] <= 34'(b18.mul_a) * 34'(b18.mul_b);
        for (int k = 1; k < 17; k++) p18[k] <= p18[k-1];
    end

    assign b4.mul_p  = p4[2];
    assign b1.mul_p  = 34'(b1.mul_a) * 34'(b1.mul_b);
    assign b18.mul_p = p18[16];

    // Operand change logs
    logic [16:0] qa4[$], qb4[$], qa1[$], qb1[$], qa18[$], qb18[$];
    logic [16:0] la4, lb4, la1, lb1, la18, lb18;

    always @(negedge clk) begin
        if ({b4.mul_a, b4.mul_b} !== {la4, lb4}) begin
            qa4.push_back(b4.mul_a);
            qb4.push_back(b4.mul_b);
            la4 = b4.mul_a;
            lb4 = b4.mul_b;
        end
        if ({b1.mul_a, b1.mul_b} !== {la1, lb1}) begin
            qa1.push_back(b1.mul_a);
            qb1.push_back(b1.mul_b);
            la1 = b1.mul_a;
            lb1 = b1.mul_b;
        end
        if ({b18.mul_a, b18.mul_b} !== {la18, lb18}) begin
            qa18.push_back(b18.mul_a);
            qb18.push_back(b18.mul_b);
            la18 = b18.mul_a;
            lb18 = b18.mul_b;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clr4();
        qa4.delete();
        qb4.delete();
    endtask

    // Start on u4, optionally poke start while busy, return cycles to done
    task automatic run4(input logic [4:0] nn, input bit poke, output int cyc);
        b4.n     = nn;
        b4.start = 1'b1;
        @(posedge clk);
        #1;
        b4.start = 1'b0;
        chk("busy_on_accept", b4.busy, 1);
        cyc = 0;
        while (cyc < 500) begin
            @(posedge clk);
            #1;
            cyc++;
            if (b4.done) break;
            b4.start = poke && (cyc % 4 == 1);
            b4.n     = poke ? 5'd3 : nn;
        end
        b4.start = 1'b0;
        b4.n     = nn;
        chk("done_seen", b4.done, 1);
        chk("busy_at_done", b4.busy, 0);
        @(posedge clk);
        #1;
        chk("done_one_cycle", b4.done, 0);
    endtask

    initial begin
        int ea[5] = '{1, 2, 6, 24, 120};
        int eb[5] = '{2, 3, 4, 5, 6};
        int cyc;
        int npulse;

        b4.start = 0;  b4.n = 0;
        b1.start = 0;  b1.n = 0;
        b18.start = 0; b18.n = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", b4.busy, 0);
        chk("rst_done", b4.done, 0);
        chk("rst_ovf", b4.overflow, 0);
        chk("rst_mul_a", b4.mul_a, 0);
        chk("rst_mul_b", b4.mul_b, 0);
        chk("rst_result", b4.result, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        clr4();

        // n=5
        run4(5'd5, 1'b0, cyc);
        chk("n5_cyc", cyc, 25);
        chk("n5_result", b4.result, 120);
        chk("n5_ovf", b4.overflow, 0);
        chk("n5_nops", qa4.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk("n5_mul_a", (k < qa4.size()) ? qa4[k] : 17'h1ffff, ea[k]);
            chk("n5_mul_b", (k < qb4.size()) ? qb4[k] : 17'h1ffff, eb[k]);
        end

        // n=0 and n=1: no multiplier traffic
        clr4();
        run4(5'd0, 1'b0, cyc);
        chk("n0_cyc", cyc, 1);
        chk("n0_result", b4.result, 1);
        run4(5'd1, 1'b0, cyc);
        chk("n1_cyc", cyc, 1);
        chk("n1_result", b4.result, 1);
        chk("n01_nops", qa4.size(), 0);

        // n=8 fits, n=9 overflows
        run4(5'd8, 1'b0, cyc);
        chk("n8_cyc", cyc, 43);
        chk("n8_result", b4.result, 40320);
        chk("n8_ovf", b4.overflow, 0);
        clr4();
        run4(5'd9, 1'b0, cyc);
        chk("n9_cyc", cyc, 49);
        chk("n9_result", b4.result, 40320);
        chk("n9_ovf", b4.overflow, 1);
        repeat (10) @(posedge clk);
        #1;
        chk("n9_nops", qa4.size(), 8);
        chk("n9_last_b", b4.mul_b, 9);
        chk("n9_idle", b4.busy, 0);

        // n=6 with start poked while busy
        run4(5'd6, 1'b1, cyc);
        chk("n6p_cyc", cyc, 31);
        chk("n6p_result", b4.result, 720);
        chk("n6p_ovf", b4.overflow, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("n6p_no_queue", b4.busy, 0);
        run4(5'd3, 1'b0, cyc);
        chk("n3_result", b4.result, 6);
        chk("n3_cyc", cyc, 13);

        // reset during WAIT of n=7
        b4.n = 5'd7;
        b4.start = 1'b1;
        @(posedge clk);
        #1;
        b4.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("n7_busy_pre", b4.busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", b4.busy, 0);
        chk("abort_result", b4.result, 1);
        chk("abort_done", b4.done, 0);
        chk("abort_mul_a", b4.mul_a, 0);
        npulse = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (b4.done || b4.busy) npulse++;
        end
        chk("abort_quiet", npulse, 0);
        run4(5'd4, 1'b0, cyc);
        chk("n4_result", b4.result, 24);
        chk("n4_cyc", cyc, 19);

        // rst and start together: rst wins
        rst = 1'b1;
        b4.n = 5'd5;
        b4.start = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        b4.start = 1'b0;
        chk("rst_start_busy", b4.busy, 0);
        @(posedge clk);
        #1;
        chk("rst_start_idle", b4.busy, 0);

        // latency 1 and 18, n=6
        qa1.delete(); qb1.delete();
        qa18.delete(); qb18.delete();
        b1.n = 5'd6;
        b18.n = 5'd6;
        b1.start = 1'b1;
        b18.start = 1'b1;
        @(posedge clk);
        #1;
        b1.start = 1'b0;
        b18.start = 1'b0;
        fork
            begin
                int c1 = 0;
                while (c1 < 500) begin
                    @(posedge clk);
                    #1;
                    c1++;
                    if (b1.done) break;
                end
                chk("l1_cyc", c1, 16);
                chk("l1_result", b1.result, 720);
            end
            begin
                int c18 = 0;
                while (c18 < 500) begin
                    @(posedge clk);
                    #1;
                    c18++;
                    if (b18.done) break;
                end
                chk("l18_cyc", c18, 101);
                chk("l18_result", b18.result, 720);
            end
        join
        chk("l1_nops", qa1.size(), 5);
        chk("l18_nops", qa18.size(), 5);
        for (int k = 0; k < 5; k++) begin
            chk("l1_mul_a", (k < qa1.size()) ? qa1[k] : 17'h1ffff, ea[k]);
            chk("l1_mul_b", (k < qb1.size()) ? qb1[k] : 17'h1ffff, eb[k]);
            chk("l18_mul_a", (k < qa18.size()) ? qa18[k] : 17'h1ffff, ea[k]);
            chk("l18_mul_b", (k < qb18.size()) ? qb18[k] : 17'h1ffff, eb[k]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
